// File: rtl/regfile_pkg.sv
// Shared constants for the pipelined MIPS register file and its pending-write scoreboard.
package regfile_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned HI_IDX     = 0;
  localparam int unsigned LO_IDX     = 1;
  localparam int unsigned HILO_N     = 2;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write bits for every GPR plus the HI/LO pair; a set and a clear on the
// same edge leave the bit set because a newer producer has already issued.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              hilo_set,
  input  logic              hilo_clr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_hilo
);
  localparam int unsigned NREGS    = 2 ** ADDR_W;
  localparam int unsigned IDX_W    = ADDR_W + 1;
  localparam int unsigned HILO_BIT = NREGS;

  logic [NREGS:0] pend;
  logic [NREGS:0] pend_nxt;
  logic           retire_a;
  logic           retire_b;

  // Clear first, then set, so a simultaneous set wins.
  always_comb begin
    pend_nxt = pend;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (clr && clr_addr == ADDR_W'(i))
        pend_nxt[i] = 1'b0;
      if (set && set_addr == ADDR_W'(i) && !(ZERO_REG && i == REG_ZERO))
        pend_nxt[i] = 1'b1;
    end
    if (hilo_clr)
      pend_nxt[HILO_BIT] = 1'b0;
    if (hilo_set)
      pend_nxt[HILO_BIT] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend <= '0;
    else
      pend <= pend_nxt;
  end

  // A retiring write hides the pending bit so it agrees with the forwarded data.
  always_comb begin
    retire_a = BYPASS && clr && (clr_addr == rd_addr_a) && !(set && set_addr == rd_addr_a);
    retire_b = BYPASS && clr && (clr_addr == rd_addr_b) && !(set && set_addr == rd_addr_b);
  end

  assign busy_a    = pend[IDX_W'(rd_addr_a)] && !retire_a;
  assign busy_b    = pend[IDX_W'(rd_addr_b)] && !retire_b;
  assign busy_hilo = pend[HILO_BIT];

endmodule

// File: rtl/regfile_bypass.sv
// Pipelined MIPS register file: two combinational read ports with optional
// writeback forwarding, a HI/LO pair, and a pending-write scoreboard for decode.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_hilo,
  input  logic              hilo_busy_set
);
  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem  [NREGS];
  logic [DATA_W-1:0] hilo [HILO_N];
  logic              wr_ok;

  assign wr_ok = we && !(ZERO_REG && wr_addr == ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        mem[i] <= '0;
      for (int unsigned i = 0; i < HILO_N; i++)
        hilo[i] <= '0;
    end else begin
      if (wr_ok)
        mem[wr_addr] <= wr_data;
      if (hilo_we) begin
        hilo[HI_IDX] <= hi_wdata;
        hilo[LO_IDX] <= lo_wdata;
      end
    end
  end

  // Read muxes: stored value, then forwarding, then the hardwired zero on top.
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    if (BYPASS && we && wr_addr == rd_addr_a)
      rd_data_a = wr_data;
    if (rst || (ZERO_REG && rd_addr_a == ADDR_W'(REG_ZERO)))
      rd_data_a = '0;

    rd_data_b = mem[rd_addr_b];
    if (BYPASS && we && wr_addr == rd_addr_b)
      rd_data_b = wr_data;
    if (rst || (ZERO_REG && rd_addr_b == ADDR_W'(REG_ZERO)))
      rd_data_b = '0;

    hi_rdata = hilo[HI_IDX];
    lo_rdata = hilo[LO_IDX];
    if (BYPASS && hilo_we && !rst) begin
      hi_rdata = hi_wdata;
      lo_rdata = lo_wdata;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set       (busy_set),
    .set_addr  (busy_addr),
    .clr       (we),
    .clr_addr  (wr_addr),
    .hilo_set  (hilo_busy_set),
    .hilo_clr  (hilo_we),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .busy_hilo (busy_hilo)
  );

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed plus randomized bench for regfile_bypass, comparing a forwarding and a
// non-forwarding instance against an array-based reference model.
module tb_regfile_bypass;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, busy_addr;
  logic        we, hilo_we, busy_set, hilo_busy_set;
  logic [31:0] wr_data, hi_wdata, lo_wdata;

  logic [31:0] rd_data_a, rd_data_b, hi_rdata, lo_rdata;
  logic        busy_a, busy_b, busy_hilo;
  logic [31:0] nb_rd_data_a, nb_rd_data_b, nb_hi_rdata, nb_lo_rdata;
  logic        nb_busy_a, nb_busy_b, nb_busy_hilo;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic        m_pend_hilo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .busy_a(busy_a), .busy_b(busy_b), .busy_hilo(busy_hilo),
    .hilo_busy_set(hilo_busy_set)
  );

  regfile_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hi_rdata(nb_hi_rdata), .lo_rdata(nb_lo_rdata),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .busy_a(nb_busy_a), .busy_b(nb_busy_b), .busy_hilo(nb_busy_hilo),
    .hilo_busy_set(hilo_busy_set)
  );

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (rst || a == 5'd0) return 32'd0;
    if (byp && we && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (rst) return 1'b0;
    if (byp && we && wr_addr == a && !(busy_set && busy_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic [31:0] exp_hi(input bit byp);
    if (rst) return 32'd0;
    return (byp && hilo_we) ? hi_wdata : m_hi;
  endfunction

  function automatic logic [31:0] exp_lo(input bit byp);
    if (rst) return 32'd0;
    return (byp && hilo_we) ? lo_wdata : m_lo;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_a",        rd_data_a,          exp_rd(rd_addr_a, 1'b1));
    chk("rd_b",        rd_data_b,          exp_rd(rd_addr_b, 1'b1));
    chk("busy_a",      32'(busy_a),        32'(exp_busy(rd_addr_a, 1'b1)));
    chk("busy_b",      32'(busy_b),        32'(exp_busy(rd_addr_b, 1'b1)));
    chk("hi",          hi_rdata,           exp_hi(1'b1));
    chk("lo",          lo_rdata,           exp_lo(1'b1));
    chk("busy_hilo",   32'(busy_hilo),     32'(rst ? 1'b0 : m_pend_hilo));
    chk("nb_rd_a",     nb_rd_data_a,       exp_rd(rd_addr_a, 1'b0));
    chk("nb_rd_b",     nb_rd_data_b,       exp_rd(rd_addr_b, 1'b0));
    chk("nb_busy_a",   32'(nb_busy_a),     32'(exp_busy(rd_addr_a, 1'b0)));
    chk("nb_busy_b",   32'(nb_busy_b),     32'(exp_busy(rd_addr_b, 1'b0)));
    chk("nb_hi",       nb_hi_rdata,        exp_hi(1'b0));
    chk("nb_lo",       nb_lo_rdata,        exp_lo(1'b0));
    chk("nb_busy_hilo", 32'(nb_busy_hilo), 32'(rst ? 1'b0 : m_pend_hilo));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pend      = 32'd0;
    m_hi        = 32'd0;
    m_lo        = 32'd0;
    m_pend_hilo = 1'b0;
  endtask

  // Architectural effect of one rising edge: retire first, then new producers.
  task automatic model_edge();
    if (we && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
    if (hilo_we) begin
      m_hi = hi_wdata;
      m_lo = lo_wdata;
    end
    if (we) m_pend[wr_addr] = 1'b0;
    if (busy_set && busy_addr != 5'd0) m_pend[busy_addr] = 1'b1;
    if (hilo_we) m_pend_hilo = 1'b0;
    if (hilo_busy_set) m_pend_hilo = 1'b1;
  endtask

  task automatic idle();
    we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    hilo_we = 1'b0; hi_wdata = 32'd0; lo_wdata = 32'd0;
    busy_set = 1'b0; busy_addr = 5'd0; hilo_busy_set = 1'b0;
  endtask

  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      rd_addr_a     = raddr();
      rd_addr_b     = ($urandom_range(0, 4) == 0) ? rd_addr_a : raddr();
      we            = 1'($urandom_range(0, 1));
      wr_addr       = raddr();
      wr_data       = $urandom;
      hilo_we       = ($urandom_range(0, 3) == 0);
      hi_wdata      = $urandom;
      lo_wdata      = $urandom;
      busy_set      = 1'($urandom_range(0, 1));
      busy_addr     = ($urandom_range(0, 3) == 0) ? wr_addr : raddr();
      hilo_busy_set = ($urandom_range(0, 3) == 0);
      cycle();
      if (rd_addr_a == rd_addr_b) begin
        chk("same_addr_data", rd_data_a, rd_data_b);
        chk("same_addr_busy", 32'(busy_a), 32'(busy_b));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    idle();
    model_reset();

    // Reset holds everything at zero.
    #1 check_all();
    chk("rst_hi", hi_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a);
      rd_addr_b = 5'(31 - a);
      cycle();
      chk("post_rst_rd", rd_data_a, 32'd0);
    end

    // Write then read r5.
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr_a = 5'd1;
    cycle();
    idle(); rd_addr_a = 5'd5;
    #1 chk("r5_rd", rd_data_a, 32'hDEADBEEF);
    cycle();

    // r0 ignores writes and never becomes pending.
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    busy_set = 1'b1; busy_addr = 5'd0; rd_addr_a = 5'd0;
    cycle();
    idle();
    #1 chk("r0_rd", rd_data_a, 32'd0);
    chk("r0_busy", 32'(busy_a), 32'd0);
    cycle();

    // Same-cycle forwarding versus pre-edge value.
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'hAAAA5555;
    cycle();
    wr_data = 32'h12345678; rd_addr_a = 5'd7;
    #1 chk("byp_rd", rd_data_a, 32'h12345678);
    chk("nobyp_rd", nb_rd_data_a, 32'hAAAA5555);
    cycle();
    idle();
    #1 chk("r7_after", nb_rd_data_a, 32'h12345678);
    cycle();

    // Scoreboard on r9: set, set-wins-over-clear, then retire.
    busy_set = 1'b1; busy_addr = 5'd9; rd_addr_a = 5'd9;
    cycle();
    idle();
    #1 chk("r9_busy", 32'(busy_a), 32'd1);
    cycle();
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; busy_set = 1'b1; busy_addr = 5'd9;
    #1 chk("r9_setwins_pre", 32'(busy_a), 32'd1);
    cycle();
    idle();
    #1 chk("r9_still_busy", 32'(busy_a), 32'd1);
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h100;
    #1 chk("r9_retire_byp", 32'(busy_a), 32'd0);
    chk("r9_retire_nobyp", 32'(nb_busy_a), 32'd1);
    cycle();
    idle();
    #1 chk("r9_clear", 32'(busy_a), 32'd0);
    cycle();

    // HI/LO pending and write.
    hilo_busy_set = 1'b1;
    cycle();
    idle();
    #1 chk("hilo_busy", 32'(busy_hilo), 32'd1);
    hilo_we = 1'b1; hi_wdata = 32'h1; lo_wdata = 32'h2;
    cycle();
    idle();
    #1 chk("hilo_clear", 32'(busy_hilo), 32'd0);
    chk("hi_val", hi_rdata, 32'h1);
    chk("lo_val", lo_rdata, 32'h2);
    cycle();

    random_cycles(400);

    // Asynchronous reset between edges clears state immediately.
    idle();
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    hilo_we = 1'b1; hi_wdata = 32'h55; lo_wdata = 32'h66;
    busy_set = 1'b1; busy_addr = 5'd12;
    cycle();
    idle(); hilo_busy_set = 1'b1;
    cycle();
    idle(); rd_addr_a = 5'd12; rd_addr_b = 5'd3;
    #1 chk("pre_rst_busy_a", 32'(busy_a), 32'd1);
    chk("pre_rst_hi", hi_rdata, 32'h55);
    chk("pre_rst_busy_hilo", 32'(busy_hilo), 32'd1);
    @(posedge clk);
    model_edge();
    #2 rst = 1'b1;
    #1 chk("arst_hi", hi_rdata, 32'd0);
    chk("arst_lo", lo_rdata, 32'd0);
    chk("arst_busy_hilo", 32'(busy_hilo), 32'd0);
    chk("arst_busy_a", 32'(busy_a), 32'd0);
    chk("arst_rd_b", rd_data_b, 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("post_arst_rd_b", nb_rd_data_b, 32'd0);

    random_cycles(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised successor to the single-cycle MIPS register file, sized for the pipelined MIPS core.
- Two combinational read ports with optional write-to-read bypass.
- Adds a HI/LO register pair for mult/div.
- Adds a per-register pending-write scoreboard so decode can detect load-use and multi-cycle hazards.

Parameters:
- DATA_W, 32, width of every register and data port.
- ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  read port A data.
- rd_data_b  out  DATA_W  read port B data.
- we  in  1  general register write enable (writeback stage).
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- hilo_we  in  1  HI/LO write enable.
- hi_wdata  in  DATA_W  HI write data.
- lo_wdata  in  DATA_W  LO write data.
- hi_rdata  out  DATA_W  HI contents.
- lo_rdata  out  DATA_W  LO contents.
- busy_set  in  1  decode issued an instruction that will write busy_addr.
- busy_addr  in  ADDR_W  destination being marked pending.
- busy_a  out  1  pending bit of rd_addr_a.
- busy_b  out  1  pending bit of rd_addr_b.
- busy_hilo  out  1  HI/LO pending (set by hilo_busy_set, cleared by hilo_we).
- hilo_busy_set  in  1  decode issued a mult/div.

Behaviour:
- Reset (rst high, asynchronous): all NREGS registers, HI and LO = 0; all pending bits = 0; busy_hilo = 0.
  - Consequently all read outputs = 0 and busy_a/busy_b = 0 while rst is asserted.
  - rst deassertion mid-sequence: the state stays cleared; the first rising edge after deassertion performs normal updates.
- Writes:
  - Registered on the rising edge when we=1.
  - With ZERO_REG=1 and wr_addr=0, the write is discarded.
  - HI and LO are written together when hilo_we=1.
- Reads:
  - Combinational, zero latency.
  - With ZERO_REG=1, address 0 returns 0 regardless of the bypass path.
- Bypass:
  - With BYPASS=1, if we=1 and wr_addr equals a read address (and is not the hardwired zero), that port returns wr_data in the same cycle.
  - The same forwarding applies to hi_rdata and lo_rdata when hilo_we=1.
  - With BYPASS=0, reads return the pre-edge stored value.
- Scoreboard (one bit per register):
  - On an edge with busy_set=1, bit[busy_addr] is set.
  - On an edge with we=1, bit[wr_addr] is cleared.
  - Same edge, same address, both set and clear: set wins. A new producer has issued; the old result retires, but the register remains pending.
  - Same edge, different addresses: both actions happen.
  - Register 0 is never set when ZERO_REG=1.
  - busy_a and busy_b are combinational lookups of the current bits.
  - With BYPASS=1, a port whose address is being cleared this cycle (and not simultaneously set) reports 0, consistent with the forwarded data.
- HI/LO pending:
  - Same rules as the register scoreboard, using hilo_busy_set (set) and hilo_we (clear); set wins on a simultaneous edge.
- Two reads of the same address both receive identical data and busy values.
- Width rules:
  - No arithmetic is performed.
  - Address compares are full ADDR_W wide.
  - All outputs are exactly DATA_W wide.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W and ADDR_W constants;
  - REG_ZERO = 0 constant;
  - HI/LO index constants.
- One sub-module, reg_scoreboard, holds:
  - the NREGS+1 pending bits (registers plus HI/LO);
  - the set/clear priority logic;
  - the two combinational lookups.
- The data array, HI/LO registers and bypass muxes stay in regfile_bypass.

Test Plan:
- Reset then read: rst pulse, then read addresses 0..31 -> all rd_data = 0, all busy = 0, hi/lo = 0.
- Write then read r5: write 0xDEADBEEF to r5, read r5 next cycle -> 0xDEADBEEF.
- r0 protection: write to r0 with we=1 -> r0 reads 0 and its busy bit never sets.
- Bypass: in the same cycle, we=1, wr_addr=7, wr_data=0x12345678, rd_addr_a=7 -> rd_data_a=0x12345678 before the edge.
  - With BYPASS=0, the same stimulus -> old value.
- Scoreboard:
  - busy_set on r9 -> busy_a=1 for rd_addr_a=9.
  - Later, we on r9 with busy_set on r9 in the same edge -> r9 stays busy.
  - A following we-only edge on r9 -> busy clears.
- HI/LO and async reset:
  - hilo_busy_set, then hilo_we writing hi=0x1, lo=0x2 -> busy_hilo clears and hi_rdata/lo_rdata = 1/2.
  - Asserting rst mid-clock after this -> hi, lo and all pending bits = 0 immediately, without waiting for an edge.
